sync_short_gen: RTL and testbench



---
 rtl/sync_short_gen_if.sv | 13 +
 rtl/sync_short_gen.sv | 152 +++++++++++++++
 tb/tb_sync_short_gen.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sync_short_gen_if.sv
// Sample stream from the L-STF generator toward the DAC FIFO / interpolator.
// {I[31:16], Q[15:0]} two's complement samples with a valid/ready handshake.
interface sync_short_gen_if;
    logic [31:0] sample_out;
    logic        sample_out_strobe;
    logic        sample_out_ready;
    logic        sample_out_last;

    modport master (output sample_out, sample_out_strobe, sample_out_last,
                    input  sample_out_ready);
    modport slave  (input  sample_out, sample_out_strobe, sample_out_last,
                    output sample_out_ready);
endinterface

// File: rtl/sync_short_gen.sv
// TX L-STF generator: streams a 16-sample short symbol R times per start pulse.
// STF_WINDOW_EN: halve the first sample and append a halved ROM[0] tail sample.
module sync_short_gen #(
    parameter int ROM_SCALE_SHIFT = 13,
    parameter int DEFAULT_REP     = 10
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       enable,
    input  logic       start,
    input  logic [3:0] num_rep,
    output logic       busy,
    output logic       done,
    sync_short_gen_if.master tx
);
`ifdef STF_WINDOW_EN
    localparam bit WIN = 1'b1;
`else
    localparam bit WIN = 1'b0;
`endif

    // ROM contents below are the 2^13-scaled table; other scalings need a new ROM.
    if (ROM_SCALE_SHIFT != 13) begin : g_bad_scale
        $error("sync_short_gen ROM is fixed at 2^13 scaling");
    end

    localparam logic [3:0]  DEF_R = 4'(DEFAULT_REP);
    localparam logic [31:0] HALF  = {16'sd188, 16'sd188};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_TAIL} state_t;

    function automatic logic [31:0] rom(input logic [3:0] a);
        case (a)
            4'd0:    rom = {16'sd377,   16'sd377};
            4'd1:    rom = {-16'sd1081, 16'sd16};
            4'd2:    rom = {-16'sd106,  -16'sd647};
            4'd3:    rom = {16'sd1171,  -16'sd106};
            4'd4:    rom = {16'sd754,   16'sd0};
            4'd5:    rom = {16'sd1171,  -16'sd106};
            4'd6:    rom = {-16'sd106,  -16'sd647};
            4'd7:    rom = {-16'sd1081, 16'sd16};
            4'd8:    rom = {16'sd377,   16'sd377};
            4'd9:    rom = {16'sd16,    -16'sd1081};
            4'd10:   rom = {-16'sd647,  -16'sd106};
            4'd11:   rom = {-16'sd106,  16'sd1171};
            4'd12:   rom = {16'sd0,     16'sd754};
            4'd13:   rom = {-16'sd106,  16'sd1171};
            4'd14:   rom = {-16'sd647,  -16'sd106};
            default: rom = {16'sd16,    -16'sd1081};
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d, rep_q, rep_d, rtot_q, rtot_d;
    logic [31:0] smp_q, smp_d;
    logic        stb_q, stb_d, last_q, last_d, busy_q, busy_d, done_q, done_d;
    logic        xfer, fin;

    assign xfer = stb_q & tx.sample_out_ready & enable;
    assign fin  = (idx_q == 4'd15) && (rep_q == rtot_q - 4'd1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       state_q <= S_IDLE;
        else if (enable) state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (xfer && fin) state_d = WIN ? S_TAIL : S_IDLE;
            S_TAIL:  if (xfer) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values for the registered outputs; everything holds unless a transfer happens.
    always_comb begin
        idx_d  = idx_q;
        rep_d  = rep_q;
        rtot_d = rtot_q;
        smp_d  = smp_q;
        stb_d  = stb_q;
        last_d = last_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                rtot_d = (num_rep == 4'd0) ? DEF_R : num_rep;
                idx_d  = 4'd0;
                rep_d  = 4'd0;
                smp_d  = WIN ? HALF : rom(4'd0);
                stb_d  = 1'b1;
                busy_d = 1'b1;
                last_d = 1'b0;
            end
            S_RUN: if (xfer) begin
                if (fin && WIN) begin
                    smp_d  = HALF;
                    last_d = 1'b1;
                end else if (fin) begin
                    smp_d  = '0;
                    stb_d  = 1'b0;
                    busy_d = 1'b0;
                    last_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    idx_d  = idx_q + 4'd1;
                    rep_d  = rep_q + {3'b000, idx_q == 4'd15};
                    smp_d  = rom(idx_d);
                    last_d = !WIN && (idx_d == 4'd15) && (rep_d == rtot_q - 4'd1);
                end
            end
            S_TAIL: if (xfer) begin
                smp_d  = '0;
                stb_d  = 1'b0;
                busy_d = 1'b0;
                last_d = 1'b0;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q  <= '0;
            rep_q  <= '0;
            rtot_q <= '0;
            smp_q  <= '0;
            stb_q  <= 1'b0;
            last_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (enable) begin
            idx_q  <= idx_d;
            rep_q  <= rep_d;
            rtot_q <= rtot_d;
            smp_q  <= smp_d;
            stb_q  <= stb_d;
            last_q <= last_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign tx.sample_out        = smp_q;
    assign tx.sample_out_strobe = stb_q;
    assign tx.sample_out_last   = last_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
endmodule

// File: tb/tb_sync_short_gen.sv
// Bench for sync_short_gen: table of whole fields vs. a sample-list model, plus corner sequences.
module tb_sync_short_gen;
`ifdef STF_WINDOW_EN
    localparam int E = 1;
`else
    localparam int E = 0;
`endif
    localparam logic [31:0] FIRST  = E ? 32'h00BC_00BC : 32'h0179_0179;
    localparam logic [31:0] SECOND = 32'hFBC7_0010;

    logic clk = 1'b0, rstn = 1'b0, enable = 1'b1, start = 1'b0;
    logic [3:0] num_rep = 4'd0;
    logic busy, done;
    sync_short_gen_if tx();

    sync_short_gen dut (.clk(clk), .rstn(rstn), .enable(enable), .start(start),
                        .num_rep(num_rep), .busy(busy), .done(done), .tx(tx));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int ri[16] = '{377, -1081, -106, 1171, 754, 1171, -106, -1081,
                   377, 16, -647, -106, 0, -106, -647, 16};
    int rq[16] = '{377, 16, -647, -106, 0, -106, -647, 16,
                   377, -1081, -106, 1171, 754, 1171, -106, -1081};

    typedef struct { logic [31:0] s; logic l; int c; } xfer_t;
    typedef struct { int nrep; int rmode; int len; logic [31:0] first; logic [31:0] second; } vec_t;
    xfer_t q[$];
    int cyc = 0, done_cnt = 0, done_cyc = -1, stall_viol = 0, rmode = 0, rcyc = 0;
    logic hold_pend = 1'b0, hold_l;
    logic [31:0] hold_s;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int i, input int qv);
        logic [15:0] a, b;
        a = i[15:0];
        b = qv[15:0];
        return {a, b};
    endfunction

    // Expected k-th sample of a field with R repetitions, straight from the symbol table.
    function automatic logic [31:0] model(input int k, input int nrep);
        int r, n;
        r = (nrep == 0) ? 10 : nrep;
        n = 16 * r;
        if (E == 1 && (k == 0 || k == n)) return pack(ri[0] >>> 1, rq[0] >>> 1);
        return pack(ri[k % 16], rq[k % 16]);
    endfunction

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       tx.sample_out_ready = 1'b1;
            1:       tx.sample_out_ready = (rcyc % 4 == 0) || (rcyc % 4 == 3);
            default: tx.sample_out_ready = 1'($urandom_range(0, 1));
        endcase
        rcyc++;
    end

    always @(negedge clk) begin
        if (!rstn) hold_pend = 1'b0;
        else begin
            cyc++;
            if (hold_pend && (tx.sample_out !== hold_s || tx.sample_out_last !== hold_l ||
                              tx.sample_out_strobe !== 1'b1)) stall_viol++;
            hold_pend = tx.sample_out_strobe && !(tx.sample_out_ready && enable);
            hold_s = tx.sample_out;
            hold_l = tx.sample_out_last;
            if (tx.sample_out_strobe && tx.sample_out_ready && enable)
                q.push_back('{tx.sample_out, tx.sample_out_last, cyc});
            if (done) begin done_cnt++; done_cyc = cyc; end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_pulse(input int nrep);
        start = 1'b1;
        num_rep = 4'(nrep);
        tick();
        start = 1'b0;
        check("lat_strobe", tx.sample_out_strobe, 1);
        check("lat_busy", busy, 1);
        check("lat_first", tx.sample_out, FIRST);
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 3000 && done_cnt == d0; i++) tick();
        check("done_timeout", done_cnt != d0, 1);
        check("done_strobe_low", tx.sample_out_strobe, 0);
        check("done_busy_low", busy, 0);
    endtask

    task automatic wait_q(input int n);
        for (int i = 0; i < 3000 && q.size() < n; i++) tick();
        check("wait_samples", q.size() >= n, 1);
    endtask

    task automatic verify(input string nm, input int nrep, input int elen, input bit consec);
        int mm = 0, lb = 0;
        check({nm, "_len"}, q.size(), elen);
        foreach (q[k]) begin
            if (q[k].s !== model(k, nrep)) mm++;
            if (q[k].l !== (k == q.size() - 1)) lb++;
        end
        check({nm, "_data_mism"}, mm, 0);
        check({nm, "_last_mism"}, lb, 0);
        if (q.size() > 0) begin
            check({nm, "_done_cyc"}, done_cyc, q[$].c + 1);
            if (consec) check({nm, "_span"}, q[$].c - q[0].c, elen - 1);
        end
    endtask

    initial begin
        vec_t vt[4];
        int d0, sv0;
        logic [31:0] fs;
        logic fstb;
        vt[0] = '{0, 0, 160 + E, FIRST, SECOND};
        vt[1] = '{1, 1, 16 + E, FIRST, SECOND};
        vt[2] = '{15, 2, 240 + E, FIRST, SECOND};
        vt[3] = '{3, 2, 48 + E, FIRST, SECOND};

        #3;
        check("rst_sample", tx.sample_out, 0);
        check("rst_strobe", tx.sample_out_strobe, 0);
        check("rst_last", tx.sample_out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        tick(); tick();
        rstn = 1'b1;
        tick();

        foreach (vt[v]) begin
            rmode = vt[v].rmode;
            q.delete();
            d0 = done_cnt;
            sv0 = stall_viol;
            start_pulse(vt[v].nrep);
            wait_done(d0);
            check("done_single", done_cnt, d0 + 1);
            tick();
            check("done_pulse_drop", done, 0);
            check("stall_hold", stall_viol, sv0);
            verify("field", vt[v].nrep, vt[v].len, vt[v].rmode == 0);
            if (q.size() > 1) begin
                check("tbl_first", q[0].s, vt[v].first);
                check("tbl_second", q[1].s, vt[v].second);
            end
        end

        // Start while busy is ignored.
        rmode = 0;
        q.delete();
        d0 = done_cnt;
        start_pulse(0);
        wait_q(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(d0);
        repeat (5) tick();
        check("busy_start_done", done_cnt, d0 + 1);
        verify("busy_start", 0, 160 + E, 1);

        // Enable gating mid-field.
        q.delete();
        d0 = done_cnt;
        start_pulse(0);
        wait_q(20);
        enable = 1'b0;
        tick();
        fs = tx.sample_out;
        fstb = tx.sample_out_strobe;
        sv0 = q.size();
        repeat (7) begin
            if (tx.sample_out !== fs || tx.sample_out_strobe !== fstb) stall_viol++;
            tick();
        end
        check("en_no_xfer", q.size(), sv0);
        check("en_strobe_held", fstb, 1);
        enable = 1'b1;
        wait_done(d0);
        check("en_done_single", done_cnt, d0 + 1);
        verify("enable", 0, 160 + E, 0);

        // Asynchronous reset mid-field.
        q.delete();
        d0 = done_cnt;
        start_pulse(0);
        wait_q(40);
        #2 rstn = 1'b0;
        #1;
        check("arst_strobe", tx.sample_out_strobe, 0);
        check("arst_busy", busy, 0);
        check("arst_last", tx.sample_out_last, 0);
        tick(); tick();
        rstn = 1'b1;
        tick(); tick();
        check("arst_no_done", done_cnt, d0);
        q.delete();
        start_pulse(0);
        wait_done(d0);
        verify("after_rst", 0, 160 + E, 1);

        // Back-to-back: start in the done cycle.
        q.delete();
        d0 = done_cnt;
        start_pulse(1);
        wait_done(d0);
        check("b2b_done_now", done, 1);
        q.delete();
        start_pulse(2);
        wait_done(d0 + 1);
        verify("b2b", 2, 32 + E, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
